// File: rtl/disp_sched.sv
// disp_sched: source scheduler for the shared 4-digit 7-segment display path.
// Picks the 4-bit source for the 16-input display mux from three requesters
// (computer override > auto-rotation > manual switches), raises the
// direct-pixel flag for the raw-pixel source, and blanks the display for a
// programmable number of ticks after every source change so that mixed
// frames are never shown.
module disp_sched #(
    parameter int TICK_DIV    = 1000,
    parameter int DWELL_TICKS = 2000,
    parameter int BLANK_TICKS = 20,
    parameter int DIRECT_SRC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  man_sel,
    input  logic        comp_en,
    input  logic [3:0]  comp_sel,
    input  logic        auto_en,
    input  logic [15:0] src_mask,
    input  logic        btn_next,
    input  logic        btn_prev,
    output logic [3:0]  sel,
    output logic        direct,
    output logic        blank,
    output logic [1:0]  mode,
    output logic        switch_pulse
);

    // Counter widths; a width of at least one bit keeps degenerate
    // parameter values (1) legal.
    localparam int PW = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
    localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam int BW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_TICKS - 1);
    localparam logic [3:0]    DIRECT_IDX = 4'(DIRECT_SRC);

    localparam logic [1:0] MODE_MAN  = 2'd0;
    localparam logic [1:0] MODE_AUTO = 2'd1;
    localparam logic [1:0] MODE_COMP = 2'd2;

    // Next enabled source above cur, searching circularly from cur+1.
    // The last probe is cur itself, so a lone set bit on cur returns cur.
    function automatic logic [3:0] find_next_up(input logic [15:0] mask,
                                                input logic [3:0]  cur);
        logic [3:0] res;
        logic       found;
        logic [3:0] idx;
        res   = cur;
        found = 1'b0;
        for (logic [4:0] i = 5'd1; i <= 5'd16; i++) begin
            idx = cur + i[3:0];
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Previous enabled source below cur, searching circularly from cur-1.
    function automatic logic [3:0] find_next_down(input logic [15:0] mask,
                                                  input logic [3:0]  cur);
        logic [3:0] res;
        logic       found;
        logic [3:0] idx;
        res   = cur;
        found = 1'b0;
        for (logic [4:0] i = 5'd1; i <= 5'd16; i++) begin
            idx = cur - i[3:0];
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Registered state
    logic [PW-1:0] presc_r;
    logic [DW-1:0] dwell_r;
    logic [BW-1:0] blank_cnt_r;
    logic          blank_skip_r;
    logic          blank_r;
    logic [3:0]    sel_r;
    logic [1:0]    mode_r;
    logic          direct_r;
    logic          pulse_r;
    logic          btn_next_q_r;
    logic          btn_prev_q_r;

    // Next-state values
    logic [PW-1:0] presc_s;
    logic          tick_s;
    logic [DW-1:0] dwell_s;
    logic [BW-1:0] blank_cnt_s;
    logic          blank_skip_s;
    logic          blank_s;
    logic [3:0]    sel_s;
    logic [1:0]    mode_s;
    logic          direct_s;
    logic          pulse_s;
    logic          step_fwd_btn_s;
    logic          step_back_btn_s;

    // Free-running prescaler producing the one-cycle scheduler tick on wrap
    always_comb begin
        tick_s = (presc_r == PRESC_LAST);
        if (tick_s) begin
            presc_s = {PW{1'b0}};
        end else begin
            presc_s = presc_r + PW'(1'b1);
        end
    end

    // Button rising edges; simultaneous edges on both buttons cancel out
    always_comb begin
        logic next_rise;
        logic prev_rise;
        next_rise = btn_next & ~btn_next_q_r;
        prev_rise = btn_prev & ~btn_prev_q_r;
        if (next_rise && prev_rise) begin
            step_fwd_btn_s  = 1'b0;
            step_back_btn_s = 1'b0;
        end else begin
            step_fwd_btn_s  = next_rise;
            step_back_btn_s = prev_rise;
        end
    end

    // Fixed-priority requester selection: computer, then auto, then manual
    always_comb begin
        if (comp_en) begin
            mode_s = MODE_COMP;
        end else if (auto_en) begin
            mode_s = MODE_AUTO;
        end else begin
            mode_s = MODE_MAN;
        end
    end

    // Target source and dwell counter for the selected mode
    always_comb begin
        sel_s   = sel_r;
        dwell_s = dwell_r;
        case (mode_s)
            MODE_COMP: begin
                sel_s   = comp_sel;
                dwell_s = {DW{1'b0}};
            end
            MODE_MAN: begin
                sel_s   = man_sel;
                dwell_s = {DW{1'b0}};
            end
            MODE_AUTO: begin
                if (src_mask == 16'h0000) begin
                    // Nothing to rotate over: park on source 0.
                    sel_s   = 4'd0;
                    dwell_s = {DW{1'b0}};
                end else if (mode_r != MODE_AUTO) begin
                    // Entering rotation: keep the current source if enabled.
                    if (src_mask[sel_r]) begin
                        sel_s = sel_r;
                    end else begin
                        sel_s = find_next_up(src_mask, sel_r);
                    end
                    dwell_s = {DW{1'b0}};
                end else if (step_fwd_btn_s) begin
                    // A button beats a coinciding dwell expiry: one step only.
                    sel_s   = find_next_up(src_mask, sel_r);
                    dwell_s = {DW{1'b0}};
                end else if (step_back_btn_s) begin
                    sel_s   = find_next_down(src_mask, sel_r);
                    dwell_s = {DW{1'b0}};
                end else if (tick_s) begin
                    if (dwell_r == DWELL_LAST) begin
                        sel_s   = find_next_up(src_mask, sel_r);
                        dwell_s = {DW{1'b0}};
                    end else begin
                        sel_s   = sel_r;
                        dwell_s = dwell_r + DW'(1'b1);
                    end
                end else begin
                    sel_s   = sel_r;
                    dwell_s = dwell_r;
                end
            end
            default: begin
                sel_s   = 4'd0;
                dwell_s = {DW{1'b0}};
            end
        endcase
    end

    // Switch detection, direct flag and post-switch blanking
    always_comb begin
        pulse_s      = (sel_s != sel_r);
        direct_s     = (sel_s == DIRECT_IDX);
        blank_s      = blank_r;
        blank_cnt_s  = blank_cnt_r;
        blank_skip_s = blank_skip_r;
        if (pulse_s) begin
            // Start (or restart) blanking. If the first blank cycle is not
            // the start of a tick period, the tick ending that partial
            // period is skipped so only full ticks are counted.
            blank_s      = 1'b1;
            blank_cnt_s  = {BW{1'b0}};
            blank_skip_s = (presc_s != {PW{1'b0}});
        end else if (blank_r && tick_s) begin
            if (blank_skip_r) begin
                blank_skip_s = 1'b0;
            end else if (blank_cnt_r == BLANK_LAST) begin
                blank_s     = 1'b0;
                blank_cnt_s = {BW{1'b0}};
            end else begin
                blank_cnt_s = blank_cnt_r + BW'(1'b1);
            end
        end else begin
            blank_s = blank_r;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r      <= {PW{1'b0}};
            dwell_r      <= {DW{1'b0}};
            blank_cnt_r  <= {BW{1'b0}};
            blank_skip_r <= 1'b0;
            blank_r      <= 1'b0;
            sel_r        <= 4'd0;
            mode_r       <= MODE_MAN;
            direct_r     <= (DIRECT_IDX == 4'd0);
            pulse_r      <= 1'b0;
            // A button held through reset must not look like a fresh edge.
            btn_next_q_r <= 1'b1;
            btn_prev_q_r <= 1'b1;
        end else begin
            presc_r      <= presc_s;
            dwell_r      <= dwell_s;
            blank_cnt_r  <= blank_cnt_s;
            blank_skip_r <= blank_skip_s;
            blank_r      <= blank_s;
            sel_r        <= sel_s;
            mode_r       <= mode_s;
            direct_r     <= direct_s;
            pulse_r      <= pulse_s;
            btn_next_q_r <= btn_next;
            btn_prev_q_r <= btn_prev;
        end
    end

    assign sel          = sel_r;
    assign direct       = direct_r;
    assign blank        = blank_r;
    assign mode         = mode_r;
    assign switch_pulse = pulse_r;

endmodule

// File: tb/tb_disp_sched.sv
// Self-checking bench for disp_sched: directed scenarios with hand-computed
// expectations, then randomized stimulus, all compared every cycle against
// a behavioural model working in cycle indices and tick arithmetic.
module tb_disp_sched;

    localparam int TD = 4;   // TICK_DIV
    localparam int DT = 3;   // DWELL_TICKS
    localparam int BT = 2;   // BLANK_TICKS
    localparam int DS = 10;  // DIRECT_SRC

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  man_sel;
    logic        comp_en;
    logic [3:0]  comp_sel;
    logic        auto_en;
    logic [15:0] src_mask;
    logic        btn_next;
    logic        btn_prev;
    logic [3:0]  sel;
    logic        direct;
    logic        blank;
    logic [1:0]  mode;
    logic        switch_pulse;

    int checks   = 0;
    int failures = 0;

    disp_sched #(
        .TICK_DIV   (TD),
        .DWELL_TICKS(DT),
        .BLANK_TICKS(BT),
        .DIRECT_SRC (DS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .man_sel     (man_sel),
        .comp_en     (comp_en),
        .comp_sel    (comp_sel),
        .auto_en     (auto_en),
        .src_mask    (src_mask),
        .btn_next    (btn_next),
        .btn_prev    (btn_prev),
        .sel         (sel),
        .direct      (direct),
        .blank       (blank),
        .mode        (mode),
        .switch_pulse(switch_pulse)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit         m_valid = 1'b0;
    int         m_c;          // cycles since reset release (tick phase = m_c % TD)
    logic [3:0] m_sel;
    logic [1:0] m_mode;
    int         m_ticks;      // ticks elapsed in the current dwell
    bit         m_pn, m_pp;   // last seen button levels
    int         m_sw = -1;    // cycle index of the latest switch
    bit         m_pulse;

    function automatic logic [3:0] m_up(input logic [15:0] mk, input int s);
        for (int i = 1; i <= 16; i++) begin
            if (mk[(s + i) % 16]) return 4'((s + i) % 16);
        end
        return 4'(s);
    endfunction

    function automatic logic [3:0] m_down(input logic [15:0] mk, input int s);
        for (int i = 1; i <= 16; i++) begin
            if (mk[(s - i + 16) % 16]) return 4'((s - i + 16) % 16);
        end
        return 4'(s);
    endfunction

    // Blank lasts the remainder of the tick period the switch lands in
    // (unless it lands on a period start) plus BT whole tick periods.
    function automatic bit exp_blank(input int c);
        int len;
        if (m_sw < 0) return 1'b0;
        len = ((m_sw % TD) == 0 ? 0 : TD - (m_sw % TD)) + BT * TD;
        return (c >= m_sw) && (c < m_sw + len);
    endfunction

    task automatic model_edge();
        bit         tick, rn, rp;
        logic [1:0] nm;
        logic [3:0] ns;
        int         nt;
        if (reset) begin
            m_valid = 1'b1;
            m_c = 0; m_sel = 4'd0; m_mode = 2'd0; m_ticks = 0;
            m_pn = 1'b1; m_pp = 1'b1; m_sw = -1; m_pulse = 1'b0;
        end else begin
            tick = ((m_c % TD) == TD - 1);
            rn = btn_next && !m_pn;
            rp = btn_prev && !m_pp;
            nm = comp_en ? 2'd2 : (auto_en ? 2'd1 : 2'd0);
            ns = m_sel;
            nt = m_ticks;
            if (nm == 2'd2) begin
                ns = comp_sel; nt = 0;
            end else if (nm == 2'd0) begin
                ns = man_sel; nt = 0;
            end else if (src_mask == 16'h0000) begin
                ns = 4'd0; nt = 0;
            end else if (m_mode != 2'd1) begin
                ns = src_mask[m_sel] ? m_sel : m_up(src_mask, m_sel); nt = 0;
            end else if (rn && !rp) begin
                ns = m_up(src_mask, m_sel); nt = 0;
            end else if (rp && !rn) begin
                ns = m_down(src_mask, m_sel); nt = 0;
            end else if (tick) begin
                nt = m_ticks + 1;
                if (nt == DT) begin
                    ns = m_up(src_mask, m_sel); nt = 0;
                end
            end
            m_pulse = (ns != m_sel);
            if (m_pulse) m_sw = m_c + 1;
            m_sel = ns; m_mode = nm; m_ticks = nt;
            m_pn = btn_next; m_pp = btn_prev;
            m_c++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_edge();
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                checks++;
                if (sel !== m_sel || mode !== m_mode || direct !== (m_sel == 4'(DS)) ||
                    switch_pulse !== m_pulse || blank !== exp_blank(m_c)) begin
                    failures++;
                    $display("FAIL model_cycle c=%0d: sel got %0d want %0d, mode got %0d want %0d, direct got %0b want %0b, pulse got %0b want %0b, blank got %0b want %0b",
                             m_c, sel, m_sel, mode, m_mode, direct, (m_sel == 4'(DS)),
                             switch_pulse, m_pulse, blank, exp_blank(m_c));
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input string name, input int maxc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (switch_pulse !== 1'b1 && n < maxc);
        if (switch_pulse !== 1'b1) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, blen, pc;
        reset = 1'b1; man_sel = 4'd5; comp_en = 1'b0; comp_sel = 4'd0;
        auto_en = 1'b0; src_mask = 16'h0000; btn_next = 1'b0; btn_prev = 1'b0;
        repeat (3) step();
        chk("reset_sel", sel, 0);
        chk("reset_mode", mode, 0);
        chk("reset_blank", blank, 0);
        chk("reset_pulse", switch_pulse, 0);
        chk("reset_direct", direct, 0);

        // Manual select straight out of reset
        reset = 1'b0;
        step();
        chk("man_sel", sel, 5);
        chk("man_mode", mode, 0);
        blen = 0; pc = 0;
        while (blank === 1'b1 && blen < 40) begin
            blen++;
            if (switch_pulse === 1'b1) pc++;
            step();
        end
        chk("man_blank_len", blen, 11);
        chk("man_pulse_count", pc, 1);

        // Auto rotation over sources 1, 4, 10
        src_mask = 16'h0412; auto_en = 1'b1;
        step();
        chk("auto_entry_sel", sel, 10);
        chk("auto_entry_direct", direct, 1);
        chk("auto_entry_mode", mode, 1);
        wait_pulse("auto_s1", 40, n);
        chk("auto_s1_sel", sel, 1);
        chk("auto_s1_direct", direct, 0);
        wait_pulse("auto_s2", 40, n);
        chk("auto_s2_gap", n, 12);
        chk("auto_s2_sel", sel, 4);
        wait_pulse("auto_s3", 40, n);
        chk("auto_s3_gap", n, 12);
        chk("auto_s3_sel", sel, 10);
        wait_pulse("auto_s4", 40, n);
        chk("auto_s4_gap", n, 12);
        chk("auto_s4_sel", sel, 1);
        wait_pulse("auto_s5", 40, n);
        chk("auto_s5_sel", sel, 4);

        // Buttons while on source 4
        btn_next = 1'b1;
        step();
        chk("btn_next_sel", sel, 10);
        chk("btn_next_pulse", switch_pulse, 1);
        btn_next = 1'b0;
        step();
        btn_prev = 1'b1;
        step();
        chk("btn_prev_sel", sel, 4);
        btn_prev = 1'b0;
        step();
        btn_next = 1'b1; btn_prev = 1'b1;
        step();
        chk("btn_both_sel", sel, 4);
        chk("btn_both_pulse", switch_pulse, 0);
        btn_next = 1'b0; btn_prev = 1'b0;
        wait_pulse("after_btn", 40, n);
        chk("after_btn_sel", sel, 10);

        // Computer override
        comp_en = 1'b1; comp_sel = 4'd9;
        step();
        chk("comp_mode", mode, 2);
        chk("comp_sel", sel, 9);
        btn_next = 1'b1;
        step();
        step();
        chk("comp_btn_ignored", sel, 9);
        btn_next = 1'b0; comp_en = 1'b0;
        step();
        chk("comp_exit_mode", mode, 1);
        chk("comp_exit_sel", sel, 10);

        // Empty mask and single-bit mask
        src_mask = 16'h0000;
        step();
        chk("mask0_sel", sel, 0);
        pc = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (switch_pulse === 1'b1) pc++;
        end
        chk("mask0_no_pulse", pc, 0);
        src_mask = 16'h0008;
        wait_pulse("mask8", 40, n);
        chk("mask8_sel", sel, 3);
        pc = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (switch_pulse === 1'b1) pc++;
        end
        chk("mask8_no_pulse", pc, 0);
        chk("mask8_hold", sel, 3);

        // Button held through reset, then reset during blanking
        btn_next = 1'b1; reset = 1'b1;
        repeat (3) step();
        src_mask = 16'h0412; reset = 1'b0;
        step();
        chk("post_reset_entry", sel, 1);
        step();
        step();
        chk("held_btn_no_step", sel, 1);
        chk("blank_before_reset", blank, 1);
        reset = 1'b1;
        step();
        chk("reset_blank_mid", blank, 0);
        chk("reset_sel_mid", sel, 0);
        chk("reset_mode_mid", mode, 0);
        reset = 1'b0; btn_next = 1'b0;

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) man_sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) comp_en = ~comp_en;
            if ($urandom_range(0, 7) == 0) comp_sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0: src_mask = 16'h0000;
                    1: src_mask = 16'h0001 << $urandom_range(0, 15);
                    default: src_mask = 16'($urandom);
                endcase
            end
            if ($urandom_range(0, 5) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 5) == 0) btn_prev = ~btn_prev;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
